// File: rtl/cache_pkg.sv
// Constants and FSM encoding shared by the cache subsystem and the memory port arbiter.
`default_nettype none

package cache_pkg;

  localparam int ADR_WIDTH      = 32;
  localparam int DATA_WIDTH     = 32;
  localparam int WORD_OFFSET    = 2;
  localparam int BEATS_PER_LINE = 1 << WORD_OFFSET;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BEAT    = 2'd1,
    GAP     = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant; the pointer moves past the owner when its burst is released.
`default_nettype none

module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       rel,
  input  logic       owner,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 1'b0;
    end else if (rel) begin
      ptr <= ~owner;
    end
  end

  assign gnt_valid = |req;
  assign gnt_idx   = (&req) ? ptr : req[1];

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// Shares one word-wide memory port between two line-burst requesters, critical word first.
// Optional per-beat ack watchdog: define MEM_PORT_ARBITER_TIMEOUT_EN.
`default_nettype none

module mem_port_arbiter
  import cache_pkg::*;
#(
  parameter int ADR_WIDTH      = cache_pkg::ADR_WIDTH,
  parameter int DATA_WIDTH     = cache_pkg::DATA_WIDTH,
  parameter int WORD_OFFSET    = cache_pkg::WORD_OFFSET,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   c0_req_i,
  input  logic                   c0_we_i,
  input  logic [ADR_WIDTH-1:0]   c0_adr_i,
  input  logic [DATA_WIDTH-1:0]  c0_wdat_i,
  output logic                   c0_ack_o,
  output logic [DATA_WIDTH-1:0]  c0_rdat_o,
  output logic [WORD_OFFSET-1:0] c0_word_o,
  output logic                   c0_done_o,
  output logic                   c0_err_o,
  input  logic                   c1_req_i,
  input  logic                   c1_we_i,
  input  logic [ADR_WIDTH-1:0]   c1_adr_i,
  input  logic [DATA_WIDTH-1:0]  c1_wdat_i,
  output logic                   c1_ack_o,
  output logic [DATA_WIDTH-1:0]  c1_rdat_o,
  output logic [WORD_OFFSET-1:0] c1_word_o,
  output logic                   c1_done_o,
  output logic                   c1_err_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [ADR_WIDTH-1:0]   mem_adr_o,
  output logic [DATA_WIDTH-1:0]  mem_dat_o,
  input  logic                   mem_ack_i,
  input  logic [DATA_WIDTH-1:0]  mem_dat_i
);

  localparam int BASE_W = ADR_WIDTH - WORD_OFFSET - 2;

  arb_state_t             state, state_nx;
  logic                   owner;
  logic                   we_q;
  logic [BASE_W-1:0]      base;
  logic [WORD_OFFSET-1:0] start, cnt, word;
  logic                   gnt_valid, gnt_idx;
  logic                   in_beat, in_rel, last_beat;
  logic                   timed_out, err_q;
  logic                   unused_adr;

  assign in_beat    = (state == BEAT);
  assign in_rel     = (state == RELEASE);
  assign word       = start + cnt;
  assign last_beat  = &cnt;
  assign unused_adr = ^{c0_adr_i[1:0], c1_adr_i[1:0]};

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       ({c1_req_i, c0_req_i}),
    .rel       (in_rel),
    .owner     (owner),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wdog;

  assign timed_out = in_beat && !mem_ack_i && (wdog == WD_W'(TIMEOUT_CYCLES - 1));

  // err_q is only observed in RELEASE, which always directly follows the timeout cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timed_out;
      if (!in_beat) begin
        wdog <= '0;
      end else if (!mem_ack_i) begin
        wdog <= wdog + 1'b1;
      end
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timed_out = 1'b0;
  assign err_q     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner <= 1'b0;
      we_q  <= 1'b0;
      base  <= '0;
      start <= '0;
      cnt   <= '0;
    end else if (state == IDLE && gnt_valid) begin
      owner <= gnt_idx;
      we_q  <= gnt_idx ? c1_we_i : c0_we_i;
      base  <= gnt_idx ? c1_adr_i[ADR_WIDTH-1:WORD_OFFSET+2] : c0_adr_i[ADR_WIDTH-1:WORD_OFFSET+2];
      start <= gnt_idx ? c1_adr_i[WORD_OFFSET+1:2] : c0_adr_i[WORD_OFFSET+1:2];
      cnt   <= '0;
    end else if (in_beat && mem_ack_i) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx  = state;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    mem_adr_o = '0;
    mem_dat_o = '0;
    c0_ack_o  = 1'b0;
    c0_rdat_o = '0;
    c0_word_o = '0;
    c0_done_o = 1'b0;
    c0_err_o  = 1'b0;
    c1_ack_o  = 1'b0;
    c1_rdat_o = '0;
    c1_word_o = '0;
    c1_done_o = 1'b0;
    c1_err_o  = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) state_nx = BEAT;
      end
      BEAT: begin
        mem_req_o = 1'b1;
        mem_we_o  = we_q;
        mem_adr_o = {base, word, 2'b00};
        mem_dat_o = owner ? c1_wdat_i : c0_wdat_i;
        if (owner) begin
          c1_word_o = word;
          c1_ack_o  = mem_ack_i;
          c1_rdat_o = mem_ack_i ? mem_dat_i : '0;
        end else begin
          c0_word_o = word;
          c0_ack_o  = mem_ack_i;
          c0_rdat_o = mem_ack_i ? mem_dat_i : '0;
        end
        if (mem_ack_i) begin
          state_nx = last_beat ? RELEASE : GAP;
        end else if (timed_out) begin
          state_nx = RELEASE;
        end
      end
      GAP: begin
        state_nx = BEAT;
      end
      RELEASE: begin
        state_nx = IDLE;
        if (owner) begin
          c1_done_o = 1'b1;
          c1_err_o  = err_q;
        end else begin
          c0_done_o = 1'b1;
          c0_err_o  = err_q;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a line-burst reference model.
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c0_req_i, c0_we_i, c1_req_i, c1_we_i;
  logic [31:0] c0_adr_i, c0_wdat_i, c1_adr_i, c1_wdat_i;
  logic        c0_ack_o, c0_done_o, c0_err_o, c1_ack_o, c1_done_o, c1_err_o;
  logic [31:0] c0_rdat_o, c1_rdat_o;
  logic [1:0]  c0_word_o, c1_word_o;
  logic        mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0] mem_adr_o, mem_dat_o, mem_dat_i;

  int checks = 0;
  int errors = 0;
  int rr_next = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .c0_req_i(c0_req_i), .c0_we_i(c0_we_i), .c0_adr_i(c0_adr_i), .c0_wdat_i(c0_wdat_i),
    .c0_ack_o(c0_ack_o), .c0_rdat_o(c0_rdat_o), .c0_word_o(c0_word_o),
    .c0_done_o(c0_done_o), .c0_err_o(c0_err_o),
    .c1_req_i(c1_req_i), .c1_we_i(c1_we_i), .c1_adr_i(c1_adr_i), .c1_wdat_i(c1_wdat_i),
    .c1_ack_o(c1_ack_o), .c1_rdat_o(c1_rdat_o), .c1_word_o(c1_word_o),
    .c1_done_o(c1_done_o), .c1_err_o(c1_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o),
    .mem_ack_i(mem_ack_i), .mem_dat_i(mem_dat_i)
  );

  // Round-robin rule: contested grant goes to rr_next, otherwise to the lone requester.
  function automatic int pick(input logic r0, input logic r1);
    if (r0 && r1) return rr_next;
    return r1 ? 1 : 0;
  endfunction

  task automatic set_req(input int port, input logic we, input logic [31:0] adr);
    if (port == 1) begin
      c1_req_i = 1'b1; c1_we_i = we; c1_adr_i = adr;
    end else begin
      c0_req_i = 1'b1; c0_we_i = we; c0_adr_i = adr;
    end
  endtask

  // Plays memory for one whole burst of the expected owner; owner wdat = wbase + word index.
  task automatic serve(input int port, input logic [31:0] wbase, input int pct);
    logic [31:0] adr, exp_adr, d, own_rdat;
    logic        we, ack, own_ack, own_done, own_err;
    logic [1:0]  start, w, own_word;
    logic [36:0] oth;
    int          beat, cyc, stall;
    adr   = (port == 1) ? c1_adr_i : c0_adr_i;
    we    = (port == 1) ? c1_we_i : c0_we_i;
    start = adr[3:2];
    cyc   = 0;
    do begin
      @(posedge clk); #1;
      mem_ack_i = 1'($urandom_range(0, 1));
      cyc++;
    end while (!mem_req_o && cyc < 20);
    checks++;
    if (cyc != 1) begin
      errors++; $display("FAIL grant_latency port%0d: got %0d cycles, want 1", port, cyc);
    end
    beat = 0; stall = 0;
    while (beat < cache_pkg::BEATS_PER_LINE) begin
      w       = start + 2'(beat);
      exp_adr = {adr[31:4], w, 2'b00};
      ack     = ($urandom_range(0, 99) < pct) || (stall >= 6);
      d       = $urandom;
      mem_ack_i = ack; mem_dat_i = d;
      if (port == 1) begin c1_wdat_i = wbase + 32'(w); c0_wdat_i = $urandom; end
      else           begin c0_wdat_i = wbase + 32'(w); c1_wdat_i = $urandom; end
      #1;
      own_ack  = (port == 1) ? c1_ack_o  : c0_ack_o;
      own_rdat = (port == 1) ? c1_rdat_o : c0_rdat_o;
      own_word = (port == 1) ? c1_word_o : c0_word_o;
      own_done = (port == 1) ? c1_done_o : c0_done_o;
      own_err  = (port == 1) ? c1_err_o  : c0_err_o;
      oth = (port == 1) ? {c0_ack_o, c0_done_o, c0_err_o, c0_word_o, c0_rdat_o}
                        : {c1_ack_o, c1_done_o, c1_err_o, c1_word_o, c1_rdat_o};
      checks++;
      if (mem_req_o !== 1'b1 || mem_we_o !== we || mem_adr_o !== exp_adr) begin
        errors++; $display("FAIL beat_req port%0d beat%0d: got req=%b we=%b adr=%h want req=1 we=%b adr=%h",
                           port, beat, mem_req_o, mem_we_o, mem_adr_o, we, exp_adr);
      end
      checks++;
      if (own_word !== w) begin
        errors++; $display("FAIL word_idx port%0d beat%0d: got %0d want %0d", port, beat, own_word, w);
      end
      if (we) begin
        checks++;
        if (mem_dat_o !== wbase + 32'(w)) begin
          errors++; $display("FAIL wr_data port%0d beat%0d: got %h want %h", port, beat, mem_dat_o, wbase + 32'(w));
        end
      end
      checks++;
      if (own_ack !== ack || (ack && own_rdat !== d) || own_done !== 1'b0 || own_err !== 1'b0) begin
        errors++; $display("FAIL beat_ack port%0d beat%0d: got ack=%b rdat=%h done=%b want ack=%b rdat=%h done=0",
                           port, beat, own_ack, own_rdat, own_done, ack, d);
      end
      checks++;
      if (oth !== 37'd0) begin
        errors++; $display("FAIL idle_port port%0d beat%0d: got %h want 0", 1 - port, beat, oth);
      end
      if (ack) begin beat++; stall = 0; end else stall++;
      @(posedge clk); #1;
      mem_ack_i = 1'($urandom_range(0, 1));
      mem_dat_i = $urandom;
      if (ack) begin
        #1;
        own_done = (port == 1) ? c1_done_o : c0_done_o;
        own_err  = (port == 1) ? c1_err_o  : c0_err_o;
        if (beat < cache_pkg::BEATS_PER_LINE) begin
          checks++;
          if (mem_req_o !== 1'b0 || own_done !== 1'b0) begin
            errors++; $display("FAIL gap port%0d beat%0d: got req=%b done=%b want 0 0", port, beat, mem_req_o, own_done);
          end
          @(posedge clk); #1;
        end else begin
          checks++;
          if (own_done !== 1'b1 || own_err !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++; $display("FAIL done port%0d: got done=%b err=%b req=%b want 1 0 0", port, own_done, own_err, mem_req_o);
          end
        end
      end
    end
    @(posedge clk); #1;
    mem_ack_i = 1'($urandom_range(0, 1));
    if (port == 1) c1_req_i = 1'b0; else c0_req_i = 1'b0;
    #1;
    own_done = (port == 1) ? c1_done_o : c0_done_o;
    checks++;
    if (mem_req_o !== 1'b0 || own_done !== 1'b0) begin
      errors++; $display("FAIL release_idle port%0d: got req=%b done=%b want 0 0", port, mem_req_o, own_done);
    end
    rr_next = 1 - port;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    c0_req_i = 1'b0; c1_req_i = 1'b0; mem_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    rr_next = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    c0_req_i = 1'b1; c1_req_i = 1'b1; c0_we_i = 1'b1; c1_we_i = 1'b1;
    c0_adr_i = $urandom; c1_adr_i = $urandom; c0_wdat_i = $urandom; c1_wdat_i = $urandom;
    mem_ack_i = 1'b1; mem_dat_i = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || mem_adr_o !== 32'd0 || mem_dat_o !== 32'd0) begin
      errors++; $display("FAIL reset_mem: got req=%b we=%b adr=%h dat=%h want all 0", mem_req_o, mem_we_o, mem_adr_o, mem_dat_o);
    end
    checks++;
    if ({c0_ack_o, c0_done_o, c0_err_o, c0_word_o, c0_rdat_o} !== 37'd0) begin
      errors++; $display("FAIL reset_c0: got ack=%b done=%b rdat=%h want 0", c0_ack_o, c0_done_o, c0_rdat_o);
    end
    checks++;
    if ({c1_ack_o, c1_done_o, c1_err_o, c1_word_o, c1_rdat_o} !== 37'd0) begin
      errors++; $display("FAIL reset_c1: got ack=%b done=%b rdat=%h want 0", c1_ack_o, c1_done_o, c1_rdat_o);
    end
    apply_reset();
  endtask

  task automatic test_port0_read();
    set_req(0, 1'b0, 32'h00CC3B43);
    serve(0, $urandom, 100);
  endtask

  task automatic test_port1_read();
    set_req(1, 1'b0, 32'h00CC3B48);
    serve(1, $urandom, 50);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    set_req(0, 1'b0, $urandom);
    set_req(1, 1'b0, $urandom);
    serve(0, $urandom, 80);
    fork
      serve(1, $urandom, 60);
      begin
        repeat (4) @(posedge clk);
        #2 set_req(0, 1'b1, $urandom);
      end
    join
    serve(0, $urandom, 60);
  endtask

  task automatic test_write();
    set_req(0, 1'b1, $urandom);
    serve(0, 32'hA0, 70);
  endtask

  task automatic test_reset_mid_burst();
    logic seen_done;
    set_req(0, 1'b0, $urandom);
    serve(0, $urandom, 90);
    set_req(1, 1'b0, $urandom);
    @(posedge clk); #1 mem_ack_i = 1'b1;
    @(posedge clk); #1 mem_ack_i = 1'b0;
    @(posedge clk); #1 mem_ack_i = 1'b1; mem_dat_i = $urandom;
    rst = 1'b0;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || c1_ack_o !== 1'b0 || c1_done_o !== 1'b0) begin
      errors++; $display("FAIL async_reset: got req=%b ack=%b done=%b want 0 0 0", mem_req_o, c1_ack_o, c1_done_o);
    end
    c1_req_i = 1'b0; mem_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    rr_next = 0;
    seen_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      seen_done = seen_done | c0_done_o | c1_done_o | mem_req_o;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++; $display("FAIL abort_quiet: got activity=%b want 0", seen_done);
    end
    set_req(0, 1'($urandom_range(0, 1)), $urandom);
    set_req(1, 1'($urandom_range(0, 1)), $urandom);
    serve(pick(1'b1, 1'b1), $urandom, 75);
    serve(1, $urandom, 75);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic [1:0] pat;
      int p;
      pat = 2'($urandom_range(1, 3));
      if (pat[0]) set_req(0, 1'($urandom_range(0, 1)), $urandom);
      if (pat[1]) set_req(1, 1'($urandom_range(0, 1)), $urandom);
      while (pat != 2'b00) begin
        p = pick(pat[0], pat[1]);
        serve(p, $urandom, int'($urandom_range(25, 100)));
        pat[p] = 1'b0;
      end
    end
  endtask

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    set_req(0, 1'b0, $urandom);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1 mem_ack_i = 1'b0;
      #1;
      if (mem_req_o) n++;
      else if (n > 0) break;
    end
    checks++;
    if (n != 64 || c0_done_o !== 1'b1 || c0_err_o !== 1'b1 || mem_req_o !== 1'b0) begin
      errors++; $display("FAIL timeout: got beats=%0d done=%b err=%b req=%b want 64 1 1 0", n, c0_done_o, c0_err_o, mem_req_o);
    end
    @(posedge clk); #1 c0_req_i = 1'b0;
    #1;
    checks++;
    if (c0_err_o !== 1'b0 || c0_done_o !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse: got err=%b done=%b want 0 0", c0_err_o, c0_done_o);
    end
    rr_next = 1;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_port0_read();
    test_port1_read();
    test_back_to_back();
    test_write();
    test_reset_mid_burst();
    test_random();
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
